// File: rtl/addsub_pkg.sv
// Shared definitions for the serial add/subtract unit.
//   state_e : FSM state encoding (IDLE, BUSY, DONE)
//   OP_ADD / OP_SUB : encoding of the op input
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit adder slice, time-multiplexed over the operand chunks
// by serial_add_sub.
//   a, b  : W-bit addends
//   cin   : carry into bit 0
//   s     : W-bit sum
//   cout  : carry out of bit W-1
module addsub_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per
// cycle, least-significant chunk first, carry rippled through a register.
// WIDTH must be an integer multiple of CHUNK.
//
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, op, cin        : operands, op (0 add / 1 sub), carry-in
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   sum, cout            : result and carry-out of MSB (sub: 1 = no borrow)
//   ovf, zero, neg       : signed overflow, result == 0, result MSB
//
// Build option: define ADDSUB_FLAGS_EN to compute ovf/zero/neg; otherwise
// those ports are tied to 0 and the flag logic is not built.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for operands, in_ready = 1
// BUSY  | one chunk per cycle, chunk index = cnt_q
// DONE  | result held, out_valid = 1 until out_ready
module serial_add_sub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int MSB    = WIDTH - 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;      // b already conditionally inverted
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic             accept;
    logic             last_chunk;
    logic [BW-1:0]    base;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_c;

    assign accept     = in_valid && (state_q == IDLE);
    assign last_chunk = (cnt_q == CW'(NCHUNK - 1));
    // Bit offset of the current chunk; never exceeds WIDTH-CHUNK.
    assign base       = BW'(cnt_q) * BW'(CHUNK);

    addsub_chunk #(.W(CHUNK)) u_chunk (
        .a    (a_q[base +: CHUNK]),
        .b    (b_q[base +: CHUNK]),
        .cin  (carry_q),
        .s    (chunk_s),
        .cout (chunk_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = (op == OP_SUB) ? ~b : b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d[base +: CHUNK] = chunk_s;
                carry_d              = chunk_c;
                if (last_chunk) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;

`ifdef ADDSUB_FLAGS_EN
    logic zero_acc_q, zero_acc_d;

    always_comb begin
        zero_acc_d = zero_acc_q;
        if (accept) begin
            zero_acc_d = 1'b1;
        end else if (state_q == BUSY) begin
            zero_acc_d = zero_acc_q & (chunk_s == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_acc_q <= 1'b0;
        end else begin
            zero_acc_q <= zero_acc_d;
        end
    end

    // Operands and result are all held in registers, so the flags are
    // stable throughout DONE.
    assign ovf  = (a_q[MSB] == b_q[MSB]) & (sum_q[MSB] != a_q[MSB]);
    assign neg  = sum_q[MSB];
    assign zero = zero_acc_q;
`else
    assign ovf  = 1'b0;
    assign neg  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule
